addr_wr_sel: RTL and testbench

// - Write-side counterpart of the staggered SRAM read-address selector: generates write addresses and

---
 rtl/addr_wr_sel.sv | 149 ++++++++++++++
 tb/tb_addr_wr_sel.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_wr_sel.sv
// addr_wr_sel: write-address / write-enable generator for the result SRAM queues.
// One serial counter per job is de-skewed into per-queue row addresses, so
// queue k writes rows 0..ROW_COUNT-1 starting k*QUEUE_SIZE cycles after queue 0.
// Optional feature: define ADDR_WR_SEL_ERR_EN to add a sticky 'err' output that
// flags a start request arriving while a job is already in progress.
module addr_wr_sel #(
  parameter int ARRAY_SIZE  = 8,
  parameter int QUEUE_COUNT = (ARRAY_SIZE + 3) / 4,
  parameter int QUEUE_SIZE  = 4,
  parameter int ROW_COUNT   = 99,
  parameter int ADDR_WIDTH  = 10,
  parameter int ADDR_IDLE   = 127
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              stall,
  output logic                              busy,
  output logic                              done,
  output logic [QUEUE_COUNT*ADDR_WIDTH-1:0] sram_waddr_packed,
  output logic [QUEUE_COUNT-1:0]            sram_wen_packed
`ifdef ADDR_WR_SEL_ERR_EN
  ,
  output logic                              err
`endif
);

  // Last counter value of a job: the last queue has just written its final row.
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = ADDR_WIDTH'((QUEUE_COUNT - 1) * QUEUE_SIZE + ROW_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] IDLE_ADDR = ADDR_WIDTH'(ADDR_IDLE);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST  = ADDR_WIDTH'(ROW_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_done;
  logic                  w_accept;
  logic                  w_advance;

  // A start is only honoured from IDLE; the counter moves only on non-stalled RUN cycles.
  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_advance = (r_state == ST_RUN) && !stall;

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: a stalled cycle never leaves RUN, even on the last count.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (start) w_nextState = ST_RUN;
      ST_RUN:  if (!stall && (r_cnt == CNT_LAST)) w_nextState = ST_DONE;
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Job counter: cleared when a job is accepted, incremented on every productive cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_advance) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Completion pulse: registered while passing through DONE, which lasts one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
    end
  end

  for (genvar k = 0; k < QUEUE_COUNT; k++) begin : g_queue
    localparam logic [ADDR_WIDTH:0] OFF = (ADDR_WIDTH + 1)'(k * QUEUE_SIZE);

    logic [ADDR_WIDTH:0]   w_diff;
    logic                  w_inWin;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic                  r_wen;

    // The extra top bit of the difference flags cnt < offset, so the window test needs
    // no separate lower-bound compare and the row address is the low bits of the difference.
    assign w_diff  = {1'b0, r_cnt} - OFF;
    assign w_inWin = !w_diff[ADDR_WIDTH] && (w_diff[ADDR_WIDTH-1:0] <= ROW_LAST);

    // Per-queue write port: address/enable from the current count; a stall drops the
    // enable but keeps the last address so the SRAM port sees no spurious change.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_waddr <= IDLE_ADDR;
        r_wen   <= 1'b0;
      end else if (w_advance) begin
        if (w_inWin) begin
          r_waddr <= w_diff[ADDR_WIDTH-1:0];
          r_wen   <= 1'b1;
        end else begin
          r_waddr <= IDLE_ADDR;
          r_wen   <= 1'b0;
        end
      end else if (r_state == ST_RUN) begin
        r_wen <= 1'b0;
      end else begin
        r_waddr <= IDLE_ADDR;
        r_wen   <= 1'b0;
      end
    end

    assign sram_waddr_packed[(k+1)*ADDR_WIDTH-1 -: ADDR_WIDTH] = r_waddr;
    assign sram_wen_packed[k] = r_wen;
  end

`ifdef ADDR_WR_SEL_ERR_EN
  logic r_err;

  // Sticky protocol error: start seen while busy; cleared by the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (start && (r_state != ST_IDLE)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_addr_wr_sel.sv
// tb_addr_wr_sel: directed bench for addr_wr_sel at defaults (two queues) plus a
// second instance with ARRAY_SIZE=12 (three queues). Expected values come from the
// cycle index relative to the edge E0 that samples start.
module tb_addr_wr_sel;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic        busy;
  logic        done;
  logic [19:0] waddr;
  logic [1:0]  wen;
  logic        start12;
  logic        busy12;
  logic        done12;
  logic [29:0] waddr12;
  logic [2:0]  wen12;
`ifdef ADDR_WR_SEL_ERR_EN
  logic        err;
  logic        err12;
`endif

  int nCompared;
  int nMismatched;

  addr_wr_sel u_dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .stall            (stall),
    .busy             (busy),
    .done             (done),
    .sram_waddr_packed(waddr),
    .sram_wen_packed  (wen)
`ifdef ADDR_WR_SEL_ERR_EN
    ,
    .err              (err)
`endif
  );

  addr_wr_sel #(.ARRAY_SIZE(12)) u_dut12 (
    .clk              (clk),
    .rst              (rst),
    .start            (start12),
    .stall            (stall),
    .busy             (busy12),
    .done             (done12),
    .sram_waddr_packed(waddr12),
    .sram_wen_packed  (wen12)
`ifdef ADDR_WR_SEL_ERR_EN
    ,
    .err              (err12)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {busy, done, wen[1:0], waddr1, waddr0} after edge j of a default job.
  // Stall is high on edges s..s+l-1 (l=0: no stall). Done lands on edge 104+l.
  function automatic logic [23:0] expVec(int j, int s, int l);
    int ns;
    int c;
    int jd;
    logic isStall;
    logic b;
    logic d;
    logic [1:0] w;
    logic [9:0] a0;
    logic [9:0] a1;
    ns = 0;
    for (int e = 1; e <= j; e++) begin
      if (l > 0 && e >= s && e < s + l) ns++;
    end
    jd = 104 + l;
    isStall = (l > 0 && j >= s && j < s + l);
    b = 1'b0;
    d = 1'b0;
    w = 2'b00;
    a0 = 10'd127;
    a1 = 10'd127;
    if (j == 0) begin
      b = 1'b1;
    end else if (j < jd) begin
      b = 1'b1;
      c = j - ns - 1;
      if (c >= 0 && c <= 98) begin
        a0 = 10'(c);
        w[0] = !isStall;
      end
      if (c >= 4 && c <= 102) begin
        a1 = 10'(c - 4);
        w[1] = !isStall;
      end
    end else if (j == jd) begin
      d = 1'b1;
    end
    return {b, d, w, a1, a0};
  endfunction

  task automatic test_reset();
    logic [23:0] obs;
    logic [34:0] obs12;
    rst = 1'b0;
    start = 1'b0;
    start12 = 1'b0;
    stall = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    obs = {busy, done, wen, waddr};
    nCompared++;
    if (obs !== {1'b0, 1'b0, 2'b00, 10'd127, 10'd127}) begin
      nMismatched++;
      $display("[TB] FAIL reset_async got %h want %h", obs, {1'b0, 1'b0, 2'b00, 10'd127, 10'd127});
    end
    tick();
    tick();
    #2;
    rst = 1'b0;
    tick();
    obs = {busy, done, wen, waddr};
    nCompared++;
    if (obs !== {1'b0, 1'b0, 2'b00, 10'd127, 10'd127}) begin
      nMismatched++;
      $display("[TB] FAIL reset_idle got %h want %h", obs, {1'b0, 1'b0, 2'b00, 10'd127, 10'd127});
    end
    obs12 = {busy12, done12, wen12, waddr12};
    nCompared++;
    if (obs12 !== {1'b0, 1'b0, 3'b000, 10'd127, 10'd127, 10'd127}) begin
      nMismatched++;
      $display("[TB] FAIL reset_idle12 got %h want %h", obs12, {1'b0, 1'b0, 3'b000, 10'd127, 10'd127, 10'd127});
    end
  endtask

  task automatic test_full_job();
    logic [23:0] obs;
    logic [23:0] exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j <= 108; j++) begin
      if (j > 0) tick();
      obs = {busy, done, wen, waddr};
      exp = expVec(j, 0, 0);
      nCompared++;
      if (obs !== exp) begin
        nMismatched++;
        $display("[TB] FAIL full_job j=%0d got %h want %h", j, obs, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [23:0] obs;
    logic [23:0] exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j <= 110; j++) begin
      if (j > 0) begin
        stall = (j >= 52 && j <= 54);
        tick();
      end
      obs = {busy, done, wen, waddr};
      exp = expVec(j, 52, 3);
      nCompared++;
      if (obs !== exp) begin
        nMismatched++;
        $display("[TB] FAIL stall j=%0d got %h want %h", j, obs, exp);
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_restart_ignored();
    logic [23:0] obs;
    logic [23:0] exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j <= 107; j++) begin
      if (j > 0) begin
        start = (j == 22 || j == 104);
        tick();
      end
      obs = {busy, done, wen, waddr};
      exp = expVec(j, 0, 0);
      nCompared++;
      if (obs !== exp) begin
        nMismatched++;
        $display("[TB] FAIL restart_ignored j=%0d got %h want %h", j, obs, exp);
      end
    end
    start = 1'b0;
`ifdef ADDR_WR_SEL_ERR_EN
    nCompared++;
    if (err !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL err_sticky got %b want 1", err);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    nCompared++;
    if (err !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL err_clear got %b want 0", err);
    end
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
`endif
  endtask

  task automatic test_reset_midjob();
    logic [23:0] obs;
    logic [23:0] exp;
    int doneSeen;
    int busySeen;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 61; j++) tick();
    obs = {busy, done, wen, waddr};
    exp = expVec(61, 0, 0);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL midjob_before got %h want %h", obs, exp);
    end
    #2;
    rst = 1'b1;
    #1;
    obs = {busy, done, wen, waddr};
    nCompared++;
    if (obs !== {1'b0, 1'b0, 2'b00, 10'd127, 10'd127}) begin
      nMismatched++;
      $display("[TB] FAIL midjob_abort got %h want %h", obs, {1'b0, 1'b0, 2'b00, 10'd127, 10'd127});
    end
    tick();
    #2;
    rst = 1'b0;
    doneSeen = 0;
    busySeen = 0;
    for (int j = 0; j < 60; j++) begin
      tick();
      if (done === 1'b1) doneSeen++;
      if (busy !== 1'b0) busySeen++;
    end
    nCompared++;
    if (doneSeen != 0 || busySeen != 0) begin
      nMismatched++;
      $display("[TB] FAIL midjob_no_done got done=%0d busy=%0d want 0 0", doneSeen, busySeen);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j <= 105; j++) begin
      if (j > 0) tick();
      obs = {busy, done, wen, waddr};
      exp = expVec(j, 0, 0);
      nCompared++;
      if (obs !== exp) begin
        nMismatched++;
        $display("[TB] FAIL midjob_restart j=%0d got %h want %h", j, obs, exp);
      end
    end
  endtask

  task automatic test_three_queues();
    logic [34:0] obs;
    logic [34:0] exp;
    logic [2:0]  expWen;
    logic [29:0] expAddr;
    int c;
    start12 = 1'b1;
    tick();
    start12 = 1'b0;
    for (int j = 0; j <= 110; j++) begin
      if (j > 0) tick();
      expWen = 3'b000;
      expAddr = {10'd127, 10'd127, 10'd127};
      c = j - 1;
      if (j >= 1 && j < 108) begin
        for (int k = 0; k < 3; k++) begin
          if (c >= 4 * k && c <= 4 * k + 98) begin
            expWen[k] = 1'b1;
            expAddr[k*10 +: 10] = 10'(c - 4 * k);
          end
        end
      end
      exp = {(j < 108), (j == 108), expWen, expAddr};
      obs = {busy12, done12, wen12, waddr12};
      nCompared++;
      if (obs !== exp) begin
        nMismatched++;
        $display("[TB] FAIL three_queues j=%0d got %h want %h", j, obs, exp);
      end
    end
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    test_reset();
    test_full_job();
    test_stall();
    test_restart_ignored();
    test_reset_midjob();
    test_three_queues();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
